// File: rtl/traffic_phase_ctrl.sv
// N-direction traffic-light sequencer: green/yellow/all-red rotation with an
// optional demand-driven skip and emergency-vehicle pre-emption.
module traffic_phase_ctrl #(
    parameter int NUM_DIRS    = 4,
    parameter int GREEN_CYC   = 8,
    parameter int YELLOW_CYC  = 3,
    parameter int ALLRED_CYC  = 1,
    parameter int DEMAND_MODE = 0,
    parameter int DIR_W       = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1,
    parameter int CNT_W       = $clog2((((GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC) > ALLRED_CYC
                                        ? ((GREEN_CYC > YELLOW_CYC) ? GREEN_CYC : YELLOW_CYC)
                                        : ALLRED_CYC) + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_DIRS-1:0]   dir_req,
    input  logic                  emerg_req,
    input  logic [DIR_W-1:0]      emerg_dir,
    output logic [2*NUM_DIRS-1:0] lights,
    output logic [DIR_W-1:0]      active_dir,
    output logic                  phase_start,
    output logic                  in_emerg
);

    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_EMERG} state_t;

    localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] Y_LOAD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(ALLRED_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic [DIR_W-1:0] r_dir;
    logic [DIR_W-1:0] r_next;
    logic             r_phase_start;

    logic             w_ev;
    logic             w_tdone;
    logic             w_found;
    logic [DIR_W-1:0] w_search;
    logic [DIR_W-1:0] w_wrap;
    logic [DIR_W-1:0] w_after;

    assign w_ev    = emerg_req && (int'(emerg_dir) < NUM_DIRS);
    assign w_tdone = (r_timer == '0);
    assign w_wrap  = (int'(r_dir) == NUM_DIRS - 1) ? '0 : DIR_W'(int'(r_dir) + 1);

    // Nearest requesting direction after r_dir; walking k downward lets the closest win.
    always_comb begin
        w_found  = 1'b0;
        w_search = r_dir;
        for (int k = NUM_DIRS - 1; k >= 1; k--) begin
            if (dir_req[(int'(r_dir) + k) % NUM_DIRS]) begin
                w_found  = 1'b1;
                w_search = DIR_W'((int'(r_dir) + k) % NUM_DIRS);
            end
        end
    end

    // Target after a yellow/all-red; with no other demand we come back to the same approach.
    assign w_after = (DEMAND_MODE != 0) ? (w_found ? w_search : r_dir) : w_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_GREEN;
            r_timer       <= G_LOAD;
            r_dir         <= '0;
            r_next        <= '0;
            r_phase_start <= 1'b1;
        end else begin
            r_phase_start <= 1'b0;
            case (r_state)
                S_GREEN: begin
                    if (w_ev && emerg_dir == r_dir) begin
                        r_state       <= S_EMERG;
                        r_phase_start <= 1'b1;
                    end else if (w_ev) begin
                        r_state <= S_YELLOW;
                        r_timer <= Y_LOAD;
                        r_next  <= w_after;
                    end else if (w_tdone) begin
                        if (DEMAND_MODE != 0 && !w_found) begin
                            r_timer <= G_LOAD;
                        end else begin
                            r_state <= S_YELLOW;
                            r_timer <= Y_LOAD;
                            r_next  <= w_after;
                        end
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end
                S_YELLOW: begin
                    if (w_tdone) begin
                        r_state <= S_ALLRED;
                        r_timer <= R_LOAD;
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end
                S_ALLRED: begin
                    if (w_tdone) begin
                        r_phase_start <= 1'b1;
                        if (w_ev) begin
                            r_state <= S_EMERG;
                            r_dir   <= emerg_dir;
                        end else begin
                            r_state <= S_GREEN;
                            r_dir   <= r_next;
                            r_timer <= G_LOAD;
                        end
                    end else begin
                        r_timer <= r_timer - CNT_W'(1);
                    end
                end
                S_EMERG: begin
                    if (!emerg_req) begin
                        r_state <= S_YELLOW;
                        r_timer <= Y_LOAD;
                        r_next  <= w_after;
                    end
                end
                default: r_state <= S_GREEN;
            endcase
        end
    end

    always_comb begin
        lights = '0;
        for (int i = 0; i < NUM_DIRS; i++) begin
            if (DIR_W'(i) == r_dir) begin
                if (r_state == S_GREEN || r_state == S_EMERG) lights[2*i +: 2] = 2'b10;
                else if (r_state == S_YELLOW)                 lights[2*i +: 2] = 2'b01;
            end
        end
    end

    assign active_dir  = r_dir;
    assign phase_start = r_phase_start;
    assign in_emerg    = (r_state == S_EMERG);

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: three configurations driven with
// scripted and random stimulus against a phase-level reference model.
module tb_traffic_phase_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam int ST_G = 0, ST_Y = 1, ST_R = 2, ST_E = 3;

    typedef struct { int n; int g; int y; int r; int dm; } cfg_t;
    typedef struct { int st; int dir; int el; int nxt; bit ps; } mst_t;
    typedef struct { logic [31:0] lt; int ad; bit ps; bit ie; } exp_t;

    logic        rst_v [3];
    logic        er_v  [3];
    logic [3:0]  ed_v  [3];
    logic [15:0] rq_v  [3];

    logic [7:0] lt0, lt1;
    logic [5:0] lt2;
    logic [1:0] ad0, ad1, ad2;
    logic       ps0, ps1, ps2, ie0, ie1, ie2;

    traffic_phase_ctrl u_dut0 (
        .clk(clk), .rst(rst_v[0]), .dir_req(rq_v[0][3:0]), .emerg_req(er_v[0]),
        .emerg_dir(ed_v[0][1:0]), .lights(lt0), .active_dir(ad0), .phase_start(ps0), .in_emerg(ie0));

    traffic_phase_ctrl #(.DEMAND_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .dir_req(rq_v[1][3:0]), .emerg_req(er_v[1]),
        .emerg_dir(ed_v[1][1:0]), .lights(lt1), .active_dir(ad1), .phase_start(ps1), .in_emerg(ie1));

    traffic_phase_ctrl #(.NUM_DIRS(3), .GREEN_CYC(2), .YELLOW_CYC(1), .ALLRED_CYC(2)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .dir_req(rq_v[2][2:0]), .emerg_req(er_v[2]),
        .emerg_dir(ed_v[2][1:0]), .lights(lt2), .active_dir(ad2), .phase_start(ps2), .in_emerg(ie2));

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur   = 0;
    cfg_t cf;
    mst_t ms;
    bit   er_r;
    int   ed_r;

    // ---------------- reference model ----------------
    function automatic int search(mst_t s, cfg_t c, logic [15:0] rq);
        for (int k = 1; k < c.n; k++)
            if (rq[(s.dir + k) % c.n]) return (s.dir + k) % c.n;
        return -1;
    endfunction

    function automatic int after(mst_t s, cfg_t c, logic [15:0] rq);
        int p;
        if (c.dm == 0) return (s.dir + 1) % c.n;
        p = search(s, c, rq);
        return (p < 0) ? s.dir : p;
    endfunction

    function automatic mst_t step(mst_t s, cfg_t c, logic [15:0] rq, bit er, int ed);
        mst_t o;
        bit   ev;
        o    = s;
        ev   = er && (ed < c.n);
        o.ps = 1'b0;
        o.el = s.el + 1;
        case (s.st)
            ST_G: begin
                if (ev && ed == s.dir) begin
                    o.st = ST_E; o.ps = 1'b1;
                end else if (ev) begin
                    o.st = ST_Y; o.el = 0; o.nxt = after(s, c, rq);
                end else if (s.el == c.g - 1) begin
                    if (c.dm != 0 && search(s, c, rq) < 0) o.el = 0;
                    else begin o.st = ST_Y; o.el = 0; o.nxt = after(s, c, rq); end
                end
            end
            ST_Y: if (s.el == c.y - 1) begin o.st = ST_R; o.el = 0; end
            ST_R: if (s.el == c.r - 1) begin
                o.ps = 1'b1; o.el = 0;
                if (ev) begin o.st = ST_E; o.dir = ed; end
                else    begin o.st = ST_G; o.dir = s.nxt; end
            end
            default: if (!er) begin o.st = ST_Y; o.el = 0; o.nxt = after(s, c, rq); end
        endcase
        return o;
    endfunction

    function automatic exp_t expect_of(mst_t s);
        exp_t e;
        e.lt = '0;
        if (s.st == ST_G || s.st == ST_E) e.lt[2*s.dir +: 2] = 2'b10;
        else if (s.st == ST_Y)            e.lt[2*s.dir +: 2] = 2'b01;
        e.ad = s.dir;
        e.ps = s.ps;
        e.ie = (s.st == ST_E);
        return e;
    endfunction

    function automatic mst_t reset_state();
        mst_t s;
        s.st = ST_G; s.dir = 0; s.el = 0; s.nxt = 0; s.ps = 1'b1;
        return s;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s inst%0d t=%0t: got %0h, expected %0h", nm, cur, $time, act, req);
        end
    endtask

    task automatic check_outputs(exp_t e, string tag);
        logic [31:0] lt;
        int ad, nonred;
        bit ps, ie;
        case (cur)
            0:       begin lt = 32'(lt0); ad = int'(ad0); ps = ps0; ie = ie0; end
            1:       begin lt = 32'(lt1); ad = int'(ad1); ps = ps1; ie = ie1; end
            default: begin lt = 32'(lt2); ad = int'(ad2); ps = ps2; ie = ie2; end
        endcase
        nonred = 0;
        for (int i = 0; i < cf.n; i++) if (lt[2*i +: 2] != 2'b00) nonred++;
        chk({tag, "_lights"}, lt, e.lt);
        chk({tag, "_active_dir"}, ad, e.ad);
        chk({tag, "_phase_start"}, 32'(ps), 32'(e.ps));
        chk({tag, "_in_emerg"}, 32'(ie), 32'(e.ie));
        chk({tag, "_nonred_le1"}, 32'(nonred <= 1), 32'd1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_outputs(e, "cyc");
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge: drive inputs for the coming posedge, predict, then advance.
    task automatic cyc(bit er, int ed, logic [15:0] rq);
        er_v[cur] = er;
        ed_v[cur] = 4'(ed);
        rq_v[cur] = rq;
        ms = step(ms, cf, rq, er, ed);
        q.push_back(expect_of(ms));
        @(negedge clk);
    endtask

    task automatic do_reset(int inst, cfg_t c);
        cur = inst;
        cf  = c;
        #2;
        rst_v[cur] = 1'b0;
        er_v[cur]  = 1'b0;
        ed_v[cur]  = '0;
        rq_v[cur]  = '0;
        #1;
        check_outputs(expect_of(reset_state()), "rst");
        @(negedge clk);
        @(negedge clk);
        rst_v[cur] = 1'b1;
        ms = reset_state();
        #1;
        check_outputs(expect_of(ms), "rel");
    endtask

    task automatic run_until(int st, int dir, logic [15:0] rq);
        int budget = 100;
        while (!(ms.st == st && ms.dir == dir) && budget > 0) begin
            cyc(1'b0, 0, rq);
            budget--;
        end
        chk("run_until_budget", 32'(budget > 0), 32'd1);
    endtask

    task automatic rand_run(int ncyc, bit use_req);
        logic [15:0] rq;
        for (int i = 0; i < ncyc; i++) begin
            if ($urandom_range(0, 24) == 0) er_r = !er_r;
            if ($urandom_range(0, 15) == 0) ed_r = $urandom_range(0, 3);
            rq = use_req ? 16'($urandom & $urandom) : 16'h0;
            cyc(er_r, ed_r, rq);
        end
    endtask

    initial begin : driver
        cfg_t ca, cb, cc;
        ca = '{n: 4, g: 8, y: 3, r: 1, dm: 0};
        cb = '{n: 4, g: 8, y: 3, r: 1, dm: 1};
        cc = '{n: 3, g: 2, y: 1, r: 2, dm: 0};
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b0; er_v[i] = 1'b0; ed_v[i] = '0; rq_v[i] = '0;
        end
        er_r = 1'b0;
        ed_r = 0;
        @(negedge clk);

        // default config: fixed rotation over one full period and the wrap
        do_reset(0, ca);
        repeat (52) cyc(1'b0, 0, 16'h0);
        // emergency toward dir3 during dir1 green, held, then released
        run_until(ST_G, 1, 16'h0);
        repeat (3) cyc(1'b0, 0, 16'h0);
        repeat (15) cyc(1'b1, 3, 16'h0);
        repeat (20) cyc(1'b0, 0, 16'h0);
        // emergency on the direction already green, held past GREEN_CYC
        run_until(ST_G, 2, 16'h0);
        repeat (2) cyc(1'b0, 0, 16'h0);
        repeat (20) cyc(1'b1, 2, 16'h0);
        repeat (15) cyc(1'b0, 0, 16'h0);
        rand_run(300, 1'b0);
        er_r = 1'b0;
        repeat (20) cyc(1'b0, 0, 16'h0);
        // asynchronous reset while dir1 is yellow
        run_until(ST_Y, 1, 16'h0);
        cyc(1'b0, 0, 16'h0);
        do_reset(0, ca);
        repeat (20) cyc(1'b0, 0, 16'h0);
        rst_v[0] = 1'b0;

        // demand mode: only dir3 requests, then no requests at all
        do_reset(1, cb);
        repeat (30) cyc(1'b0, 0, 16'h8);
        do_reset(1, cb);
        repeat (30) cyc(1'b0, 0, 16'h0);
        rand_run(300, 1'b1);
        rst_v[1] = 1'b0;

        // three directions, short phases; out-of-range emergency is ignored
        er_r = 1'b0;
        do_reset(2, cc);
        repeat (45) cyc(1'b0, 0, 16'h0);
        repeat (10) cyc(1'b1, 3, 16'h0);
        rand_run(200, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
